// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU; op 111 is an iterative shift-add MUL when ALU_SEQ_MUL_EN is defined, else W=B.
// Latency 1 cycle (MUL: WIDTH+1); in_ready low while BUSY or while a DONE result is stalled by out_ready=0.
module alu_seq #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             C,
   input  logic [2:0]       opcode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] W,
   output logic             zero,
   output logic             negative,
   output logic             carry,
   output logic             overflow
);

   localparam int SHW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic [WIDTH-1:0] w;
      logic             cy;
      logic             ov;
   } res_t;

   state_t state_q, state_d;
   res_t   res_q, res_d;
   res_t   op_res;

   logic [WIDTH:0] add_u;
   logic [WIDTH:0] sub_u;

`ifdef ALU_SEQ_MUL_EN
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [CW-1:0]    cnt_q, cnt_d;
`endif

   // Carry and borrow fall out of bit WIDTH of the zero-extended sum/difference.
   always_comb begin
      add_u = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, C};
      sub_u = {1'b0, A} - {1'b0, B} - {{WIDTH{1'b0}}, C};
   end

   always_comb begin
      op_res = '0;
      case (opcode)
         3'b000: begin
            op_res.w  = add_u[WIDTH-1:0];
            op_res.cy = add_u[WIDTH];
            op_res.ov = (A[WIDTH-1] == B[WIDTH-1]) && (add_u[WIDTH-1] != A[WIDTH-1]);
         end
         3'b001: begin
            op_res.w  = sub_u[WIDTH-1:0];
            op_res.cy = sub_u[WIDTH];
            op_res.ov = (A[WIDTH-1] != B[WIDTH-1]) && (sub_u[WIDTH-1] != A[WIDTH-1]);
         end
         3'b010:  op_res.w = A & B;
         3'b011:  op_res.w = A | B;
         3'b100:  op_res.w = A ^ B;
         3'b101:  op_res.w = ~A;
         3'b110:  op_res.w = A << B[SHW-1:0];
`ifdef ALU_SEQ_MUL_EN
         default: op_res.w = '0;
`else
         default: op_res.w = B;
`endif
      endcase
   end

   always_comb begin
      state_d   = state_q;
      res_d     = res_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
`ifdef ALU_SEQ_MUL_EN
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      cnt_d     = cnt_q;
`endif

      case (state_q)
         IDLE: in_ready = 1'b1;
         BUSY: begin
`ifdef ALU_SEQ_MUL_EN
            // One multiplier bit per cycle; the product lands in W on the last bit.
            if (mplier_q[0]) begin
               acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               state_d  = DONE;
               res_d.w  = acc_d;
               res_d.cy = 1'b0;
               res_d.ov = 1'b0;
               cnt_d    = '0;
            end
`else
            state_d = IDLE;
`endif
         end
         DONE: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
            if (out_ready && !in_valid) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (in_valid && in_ready) begin
`ifdef ALU_SEQ_MUL_EN
         if (opcode == 3'b111) begin
            state_d  = BUSY;
            acc_d    = '0;
            mcand_d  = A;
            mplier_d = B;
            cnt_d    = '0;
         end else begin
            state_d = DONE;
            res_d   = op_res;
         end
`else
         state_d = DONE;
         res_d   = op_res;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         res_q    <= '0;
`ifdef ALU_SEQ_MUL_EN
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         res_q    <= res_d;
`ifdef ALU_SEQ_MUL_EN
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
`endif
      end
   end

   assign W        = res_q.w;
   assign carry    = res_q.cy;
   assign overflow = res_q.ov;
   assign zero     = (res_q.w == '0);
   assign negative = res_q.w[WIDTH-1];

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq at WIDTH=16: directed corner cases then randomized ops against an arithmetic model.
module tb_alu_seq;

   localparam int WIDTH = 16;
`ifdef ALU_SEQ_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] A;
   logic [15:0] B;
   logic        C;
   logic [2:0]  opcode;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] W;
   logic        zero;
   logic        negative;
   logic        carry;
   logic        overflow;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [15:0] w;
      logic        c;
      logic        v;
   } exp_t;

   alu_seq #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .C(C), .opcode(opcode),
      .out_valid(out_valid), .out_ready(out_ready), .W(W),
      .zero(zero), .negative(negative), .carry(carry), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      checks++;
      assert (got === want)
      else begin
         failures++;
         $error("FAIL %s: got=%0h expected=%0h", tag, got, want);
      end
   endtask

   // Plain integer arithmetic: unsigned value for W/carry, signed value range for overflow.
   function automatic exp_t model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                  input logic c);
      exp_t   e;
      longint ua, ub, uc, sa, sb, r;
      ua = longint'(a);
      ub = longint'(b);
      uc = longint'(c);
      sa = a[15] ? ua - 65536 : ua;
      sb = b[15] ? ub - 65536 : ub;
      e.c = 1'b0;
      e.v = 1'b0;
      case (op)
         3'd0: begin
            r   = ua + ub + uc;
            e.w = r[15:0];
            e.c = (r >= 65536);
            r   = sa + sb + uc;
            e.v = (r > 32767) || (r < -32768);
         end
         3'd1: begin
            r   = ua - ub - uc;
            e.w = r[15:0];
            e.c = (ua < ub + uc);
            r   = sa - sb - uc;
            e.v = (r > 32767) || (r < -32768);
         end
         3'd2: e.w = a & b;
         3'd3: e.w = a | b;
         3'd4: e.w = a ^ b;
         3'd5: e.w = ~a;
         3'd6: begin
            r   = ua << (ub % 16);
            e.w = r[15:0];
         end
         default: begin
            if (MUL_EN) begin
               r   = ua * ub;
               e.w = r[15:0];
            end else begin
               e.w = b;
            end
         end
      endcase
      return e;
   endfunction

   function automatic logic [15:0] pick();
      case ($urandom_range(0, 5))
         0:       return 16'h0000;
         1:       return 16'hFFFF;
         2:       return 16'h8000;
         3:       return 16'h7FFF;
         default: return 16'($urandom);
      endcase
   endfunction

   // Called #1 after a rising edge with the DUT idle; returns #1 after the edge that drains the result.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic c, input int stall);
      exp_t e;
      int   lat, nrdy, exp_lat;
      e       = model(op, a, b, c);
      exp_lat = (op == 3'd7 && MUL_EN) ? WIDTH + 1 : 1;
      in_valid  = 1'b1;
      opcode    = op;
      A         = a;
      B         = b;
      C         = c;
      out_ready = (stall == 0);
      #1;
      check({tag, "_in_ready"}, in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      A        = 16'($urandom);
      B        = 16'($urandom);
      C        = 1'($urandom);
      lat  = 1;
      nrdy = 0;
      while (!out_valid && lat <= 40) begin
         if (!in_ready) nrdy++;
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_busy_rdy_low"}, nrdy, exp_lat - 1);
      check({tag, "_W"}, W, e.w);
      check({tag, "_flags"}, {zero, negative, carry, overflow},
            {(e.w == 16'h0), e.w[15], e.c, e.v});
      for (int k = 0; k < stall; k++) begin
         @(posedge clk); #1;
         check({tag, "_hold"}, {out_valid, in_ready, W}, {1'b1, 1'b0, e.w});
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check({tag, "_drain"}, out_valid, 0);
   endtask

   logic [15:0] xa[4];
   logic [15:0] xb[4];
   logic [15:0] hold_w;

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      A         = '0;
      B         = '0;
      C         = 1'b0;
      opcode    = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset_state", {out_valid, in_ready, W, zero, negative, carry, overflow},
            {1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0});

      run_op("add_wrap", 3'd0, 16'hFFFF, 16'h0001, 1'b0, 0);
      run_op("sub_ovf", 3'd1, 16'h8000, 16'h0001, 1'b0, 0);
      run_op("sub_borrow", 3'd1, 16'd3, 16'd5, 1'b0, 0);
      run_op("add_cin", 3'd0, 16'h7FFF, 16'h0000, 1'b1, 0);
      run_op("sub_bin", 3'd1, 16'd5, 16'd5, 1'b1, 0);
      run_op("shl_15", 3'd6, 16'h0003, 16'h001F, 1'b0, 0);
      run_op("not", 3'd5, 16'h00FF, 16'h1234, 1'b0, 0);
      run_op("mul_300", 3'd7, 16'd300, 16'd300, 1'b0, 0);
      run_op("op7_7_9", 3'd7, 16'd7, 16'd9, 1'b0, 0);

      // Four XORs back-to-back with both handshakes held high.
      for (int i = 0; i < 4; i++) begin
         xa[i] = 16'($urandom);
         xb[i] = 16'($urandom);
      end
      opcode    = 3'd4;
      A         = xa[0];
      B         = xb[0];
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
         check("b2b_valid", {out_valid, in_ready}, 2'b11);
         check("b2b_W", W, model(3'd4, xa[i], xb[i], 1'b0).w);
         if (i < 3) begin
            A = xa[i + 1];
            B = xb[i + 1];
         end else begin
            in_valid = 1'b0;
         end
         @(posedge clk); #1;
      end
      check("b2b_idle", out_valid, 0);

      // Result stalled in DONE while the inputs keep changing.
      A         = 16'hA5A5;
      B         = 16'h0FF0;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      hold_w    = model(3'd4, A, B, 1'b0).w;
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
         A      = 16'($urandom);
         B      = 16'($urandom);
         opcode = 3'd0;
         check("stall_hold", {out_valid, in_ready, W}, {1'b1, 1'b0, hold_w});
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      check("stall_release_rdy", in_ready, 1);
      @(posedge clk); #1;
      check("stall_idle", out_valid, 0);

      // Reset lands in cycle 5 of a MUL while a new op is also offered.
      opcode   = 3'd7;
      A        = 16'd300;
      B        = 16'd300;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst      = 1'b1;
      in_valid = 1'b1;
      opcode   = 3'd0;
      A        = 16'd1;
      B        = 16'd1;
      @(posedge clk); #1;
      rst      = 1'b0;
      in_valid = 1'b0;
      check("rst_mid_state", {out_valid, in_ready, W, zero, negative, carry, overflow},
            {1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0});
      run_op("rst_add", 3'd0, 16'd2, 16'd3, 1'b0, 0);
      run_op("rst_mul", 3'd7, 16'd300, 16'd300, 1'b0, 1);

      for (int n = 0; n < 40; n++) begin
         run_op("rnd", 3'($urandom_range(0, 7)), pick(), pick(), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 2)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: WIDTH, default 16, operand/result width in bits (legal range 4..64).
REQ-002 Ports, one per line:
 clk  input  1  single clock; all state updates on its rising edge.
 rst  input  1  synchronous, active-high reset.
 in_valid  input  1  operand set presented.
 in_ready  output  1  block accepts the operand set this cycle.
 A  input  WIDTH  operand A.
 B  input  WIDTH  operand B.
 C  input  1  carry/borrow in.
 opcode  input  3  operation select.
 out_valid  output  1  result held on W and the flags.
 out_ready  input  1  consumer takes the result.
 W  output  WIDTH  result.
 zero  output  1  W == 0.
 negative  output  1  W[WIDTH-1].
 carry  output  1  carry/borrow out of ADD/SUB; 0 for all other ops.
 overflow  output  1  two's-complement overflow of ADD/SUB; 0 for all other ops.
REQ-003 The design SHALL use one clock; reset SHALL be synchronous and active-high.

Function
REQ-004 Accept: SHALL occur when in_valid && in_ready on a rising edge; A, B, C and opcode SHALL be captured at that edge.
REQ-005 Opcodes: SHALL be 000 ADD W=A+B+C; 001 SUB W=A-B-C; 010 AND; 011 OR; 100 XOR; 101 NOT A; 110 SHL W=A<<B[log2(WIDTH)-1:0]; 111 MUL W=low WIDTH bits of A*B (unsigned).
REQ-006 SUB carry SHALL be the borrow, i.e. 1 when A < B+C unsigned.
REQ-007 FSM SHALL have states IDLE, BUSY, DONE.
REQ-008 IDLE: in_ready=1; accepting a single-cycle op (000-110) SHALL go to DONE, with the result and flags registered at the accepting edge; accepting MUL SHALL go to BUSY.
REQ-009 BUSY: in_ready=0, out_valid=0; shift-add SHALL process one multiplier bit per cycle. After exactly WIDTH BUSY cycles, the FSM SHALL enter DONE with the product.
REQ-010 DONE: out_valid=1; W and the flags SHALL be stable until out_ready=1.
REQ-011 DONE && out_ready && in_valid: in_ready SHALL be 1, and the new operation SHALL be accepted in the same cycle (back-to-back; single-cycle ops sustain 1 result/cycle).
REQ-012 DONE && out_ready && !in_valid: the FSM SHALL go to IDLE with out_valid=0 in the next cycle.
REQ-013 Latency: single-cycle ops SHALL have out_valid high in the cycle after acceptance; MUL SHALL have out_valid high WIDTH+1 cycles after acceptance.
REQ-014 Arithmetic SHALL be modulo 2^WIDTH; zero and negative SHALL be derived from the registered W for every opcode.
REQ-015 A shift amount >= WIDTH is impossible by REQ-005 masking; SHL SHALL shift in zeros.
REQ-016 Input changes while in_ready=0 SHALL be ignored.

Reset
REQ-017 rst=1 at any edge, including mid-MUL or in DONE, SHALL set state=IDLE, W=0, zero=1, negative=0, carry=0, overflow=0, out_valid=0, and clear the multiplier accumulator/counter; in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-018 Reset SHALL take priority over all handshakes in the same cycle.

Configuration
REQ-019 Macro ALU_SEQ_MUL_EN: when defined, opcode 111 SHALL be the iterative MUL of REQ-009.
REQ-020 Without ALU_SEQ_MUL_EN: opcode 111 SHALL be single-cycle with W=B, carry=0, overflow=0; BUSY SHALL be unreachable and the multiplier logic SHALL not be synthesized.

Verification (WIDTH=16, ALU_SEQ_MUL_EN defined unless stated)
REQ-021 ADD A=16'hFFFF, B=16'h0001, C=0, out_ready=1 -> next cycle out_valid=1, W=0, zero=1, carry=1, overflow=0.
REQ-022 SUB A=16'h8000, B=16'h0001, C=0 -> W=16'h7FFF, overflow=1, carry=0, negative=0; SUB A=3, B=5, C=0 -> W=16'hFFFE, carry=1, negative=1.
REQ-023 MUL A=300, B=300 -> in_ready=0 for 16 cycles, out_valid exactly 17 cycles after accept, W=16'h5F90 (90000 mod 65536).
REQ-024 Back-to-back: 4 consecutive XOR ops with in_valid=1 and out_ready=1 held -> 4 results on 4 consecutive cycles; with out_ready=0 in DONE -> W held and in_ready=0 until out_ready rises.
REQ-025 rst=1 during cycle 5 of a MUL -> next cycle out_valid=0, W=0, zero=1, in_ready=1; a following ADD 2+3 gives W=5.
REQ-026 ALU_SEQ_MUL_EN undefined: opcode 111, A=7, B=9 -> W=9 one cycle after acceptance, carry=0.
